// File: rtl/timer_pkg.sv
// timer_pkg: register offsets, MMIO FSM encoding and strobe/hold timing shared by the timer and its bus interface.
package timer_pkg;
    localparam logic [7:0] OFF_CTRL       = 8'h00;
    localparam logic [7:0] OFF_MTIMECMP_L = 8'h04;
    localparam logic [7:0] OFF_MTIMECMP_H = 8'h08;
    localparam logic [7:0] OFF_MTIME_L    = 8'h0C;
    localparam logic [7:0] OFF_MTIME_H    = 8'h10;
    localparam logic [7:0] OFF_STATUS     = 8'h14;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STROBE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [1:0] S_ACK    = 2'd3;
    localparam int STROBE_CYCLES = 2;
    localparam int HOLD_CYCLES   = 2;
    typedef enum logic [1:0] {SEL_NONE, SEL_EN, SEL_L, SEL_H} wsel_t;
endpackage

// File: rtl/timer_mmio_if.sv
// timer_mmio_if: CPU register window onto the timer; writes are handed over as timed strobes,
// reads of the 64-bit counter are made atomic through a high-word shadow captured on the low read.
module timer_mmio_if
    import timer_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [31:0]       bus_wdata,
    output logic              bus_ack,
    output logic              bus_err,
    output logic [31:0]       bus_rdata,
    output logic              en,
    output logic              wr_en,
    output logic              wr_mtimecmp_in_l,
    output logic              wr_mtimecmp_in_h,
    output logic [31:0]       mtimecmp_in_l,
    output logic [31:0]       mtimecmp_in_h,
    input  logic [31:0]       mtime_l,
    input  logic [31:0]       mtime_h,
    input  logic              timer_int
);
    logic [1:0]  state;
    logic        phase;
    wsel_t       sel, wsel;
    logic [31:0] shadow, rd_val;
    logic        hit_ctrl, hit_l, hit_h, hit_ml, hit_mh, hit_st, accept, is_err;

    always_comb begin
        hit_ctrl = bus_addr == ADDR_W'(OFF_CTRL);
        hit_l    = bus_addr == ADDR_W'(OFF_MTIMECMP_L);
        hit_h    = bus_addr == ADDR_W'(OFF_MTIMECMP_H);
        hit_ml   = bus_addr == ADDR_W'(OFF_MTIME_L);
        hit_mh   = bus_addr == ADDR_W'(OFF_MTIME_H);
        hit_st   = bus_addr == ADDR_W'(OFF_STATUS);
        accept   = state == S_IDLE && bus_req;
        is_err   = bus_we ? !(hit_ctrl || hit_l || hit_h)
                          : !(hit_ctrl || hit_l || hit_h || hit_ml || hit_mh || hit_st);
        wsel     = hit_ctrl ? SEL_EN : hit_l ? SEL_L : hit_h ? SEL_H : SEL_NONE;
        rd_val   = hit_ctrl ? {31'd0, en} :
                   hit_l    ? mtimecmp_in_l :
                   hit_h    ? mtimecmp_in_h :
                   hit_ml   ? mtime_l :
                   hit_mh   ? shadow :
                   hit_st   ? {31'd0, timer_int} : 32'd0;
    end

    assign bus_ack          = state == S_ACK;
    assign wr_en            = state == S_STROBE && sel == SEL_EN;
    assign wr_mtimecmp_in_l = state == S_STROBE && sel == SEL_L;
    assign wr_mtimecmp_in_h = state == S_STROBE && sel == SEL_H;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= S_IDLE;
            phase         <= 1'b0;
            sel           <= SEL_NONE;
            bus_err       <= 1'b0;
            bus_rdata     <= 32'd0;
            en            <= 1'b0;
            mtimecmp_in_l <= 32'hFFFF_FFFF;
            mtimecmp_in_h <= 32'hFFFF_FFFF;
            shadow        <= 32'd0;
        end else begin
            // response registers are loaded only on acceptance, so they read 0 outside ACK
            bus_rdata <= (accept && !bus_we && !is_err) ? rd_val : 32'd0;
            bus_err   <= accept && is_err;
            if (state == S_IDLE) begin
                if (bus_req) begin
                    if (bus_we && !is_err) begin
                        state <= S_STROBE;
                        phase <= 1'b0;
                        sel   <= wsel;
                        if (hit_ctrl) en <= bus_wdata[0];
                        if (hit_l) mtimecmp_in_l <= bus_wdata;
                        if (hit_h) mtimecmp_in_h <= bus_wdata;
                    end else begin
                        state <= S_ACK;
                    end
                    if (!bus_we && hit_ml) shadow <= mtime_h;
                end
            end else if (state == S_STROBE) begin
                state <= (phase == 1'(STROBE_CYCLES - 1)) ? S_HOLD : S_STROBE;
                phase <= (phase == 1'(STROBE_CYCLES - 1)) ? 1'b0 : phase + 1'b1;
            end else if (state == S_HOLD) begin
                state <= (phase == 1'(HOLD_CYCLES - 1)) ? S_ACK : S_HOLD;
                phase <= (phase == 1'(HOLD_CYCLES - 1)) ? 1'b0 : phase + 1'b1;
            end else begin
                state <= S_IDLE;
                sel   <= SEL_NONE;
            end
        end
    end
endmodule

// File: tb/tb_timer_mmio_if.sv
// tb_timer_mmio_if: scoreboard bench for timer_mmio_if driven by a simple counting timer.
module tb_timer_mmio_if;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        bus_req = 1'b0, bus_we = 1'b0;
    logic [4:0]  bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_ack, bus_err, en, wr_en, wr_mtimecmp_in_l, wr_mtimecmp_in_h, timer_int;
    logic [31:0] bus_rdata, mtimecmp_in_l, mtimecmp_in_h, mtime_l, mtime_h;

    logic [63:0] mtime = '0, ld_val = '0;
    logic        ld = 1'b0, run = 1'b0;

    timer_mmio_if #(.ADDR_W(5)) dut (
        .CLK(CLK), .RST(RST), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
        .en(en), .wr_en(wr_en), .wr_mtimecmp_in_l(wr_mtimecmp_in_l),
        .wr_mtimecmp_in_h(wr_mtimecmp_in_h), .mtimecmp_in_l(mtimecmp_in_l),
        .mtimecmp_in_h(mtimecmp_in_h), .mtime_l(mtime_l), .mtime_h(mtime_h), .timer_int(timer_int)
    );

    always #5 CLK = ~CLK;

    // stand-in timer: free-running 64-bit counter compared against the programmed mtimecmp
    always @(posedge CLK) begin
        if (ld) mtime <= ld_val;
        else if (run && en) mtime <= mtime + 64'd1;
    end
    assign mtime_l   = mtime[31:0];
    assign mtime_h   = mtime[63:32];
    assign timer_int = mtime >= {mtimecmp_in_h, mtimecmp_in_l};

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [5:0]  mask;
        int          n_en, n_l, n_h;
        logic        m_en;
        logic [31:0] ml, mh;
    } exp_t;

    exp_t q[$];
    int cyc = 0, issue_cyc = 0;
    int checks = 0, fails = 0;
    logic        m_en;
    logic [31:0] m_l, m_h, m_shadow;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_en = 1'b0;
        m_l = 32'hFFFF_FFFF;
        m_h = 32'hFFFF_FFFF;
        m_shadow = 32'd0;
    endfunction

    // monitor: per-transaction strobe tracking and scoreboard pop on bus_ack
    int n_en = 0, n_l = 0, n_h = 0;
    logic [5:0] mask = '0;
    always @(negedge CLK) begin
        if (RST) begin
            n_en = 0; n_l = 0; n_h = 0; mask = '0;
        end else begin
            int s, off;
            exp_t e;
            s = int'(wr_en) + int'(wr_mtimecmp_in_l) + int'(wr_mtimecmp_in_h);
            off = cyc - issue_cyc;
            if (s != 0) begin
                chk("strobe_onehot", 64'(s > 1), 64'd0);
                if (off >= 0 && off < 6) mask[off] = 1'b1;
                n_en += int'(wr_en); n_l += int'(wr_mtimecmp_in_l); n_h += int'(wr_mtimecmp_in_h);
            end
            if (bus_ack) begin
                if (q.size() == 0) begin
                    chk("unexpected_ack", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("resp_err", 64'(bus_err), 64'(e.err));
                    chk("resp_rdata", 64'(bus_rdata), 64'(e.rdata));
                    chk("ack_latency", 64'(off), 64'(e.lat));
                    chk("strobe_timing", 64'(mask), 64'(e.mask));
                    chk("strobe_counts", 64'({n_en[7:0], n_l[7:0], n_h[7:0]}),
                        64'({e.n_en[7:0], e.n_l[7:0], e.n_h[7:0]}));
                    chk("regs", {31'd0, en, mtimecmp_in_l} ^ {32'd0, mtimecmp_in_h},
                        {31'd0, e.m_en, e.ml} ^ {32'd0, e.mh});
                    chk("cmp_h", 64'(mtimecmp_in_h), 64'(e.mh));
                end
                n_en = 0; n_l = 0; n_h = 0; mask = '0;
            end else begin
                chk("idle_resp_zero", {31'd0, bus_err, bus_rdata}, 64'd0);
            end
        end
    end

    task automatic xact(input bit we, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        bit rw, ro, got;
        @(negedge CLK);
        rw = a == 5'h00 || a == 5'h04 || a == 5'h08;
        ro = a == 5'h0C || a == 5'h10 || a == 5'h14;
        e = '{err: 1'b0, rdata: 32'd0, lat: 1, mask: 6'd0, n_en: 0, n_l: 0, n_h: 0,
              m_en: 1'b0, ml: 32'd0, mh: 32'd0};
        if (we && rw) begin
            e.lat = 5;
            e.mask = 6'b000110;
            if (a == 5'h00) begin m_en = d[0]; e.n_en = 2; end
            if (a == 5'h04) begin m_l = d; e.n_l = 2; end
            if (a == 5'h08) begin m_h = d; e.n_h = 2; end
        end else if (!we && (rw || ro)) begin
            case (a)
                5'h00: e.rdata = {31'd0, m_en};
                5'h04: e.rdata = m_l;
                5'h08: e.rdata = m_h;
                5'h0C: begin e.rdata = mtime[31:0]; m_shadow = mtime[63:32]; end
                5'h10: e.rdata = m_shadow;
                default: e.rdata = {31'd0, mtime >= {m_h, m_l}};
            endcase
        end else begin
            e.err = 1'b1;
        end
        e.m_en = m_en; e.ml = m_l; e.mh = m_h;
        q.push_back(e);
        issue_cyc = cyc;
        bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = d;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge CLK);
            got = bus_ack;
        end
        if (!got) begin
            chk("ack_timeout", 64'd0, 64'd1);
            q.delete();
        end
        bus_req = 1'b0;
    endtask

    task automatic load_mtime(input logic [63:0] v);
        @(negedge CLK);
        ld = 1'b1; ld_val = v;
        @(negedge CLK);
        ld = 1'b0;
    endtask

    initial begin
        bit seen;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("rst_outputs", {29'd0, bus_ack, bus_err, en, bus_rdata}, 64'd0);
        chk("rst_cmp", {mtimecmp_in_h, mtimecmp_in_l}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_strobes", 64'({wr_en, wr_mtimecmp_in_l, wr_mtimecmp_in_h}), 64'd0);
        RST = 1'b0;

        xact(1'b1, 5'h00, 32'd1);
        load_mtime(64'd0);
        run = 1'b1;
        xact(1'b1, 5'h04, 32'h10);
        xact(1'b1, 5'h08, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge CLK);
            seen = timer_int;
        end
        chk("timer_int_rise", 64'(seen), 64'd1);
        xact(1'b0, 5'h14, 32'd0);
        run = 1'b0;

        load_mtime(64'h1_FFFF_FFFF);
        xact(1'b0, 5'h0C, 32'd0);
        load_mtime(64'h2_0000_0000);
        xact(1'b0, 5'h10, 32'd0);

        xact(1'b1, 5'h0C, 32'd5);
        xact(1'b0, 5'h18, 32'd0);
        xact(1'b0, 5'h06, 32'd0);

        @(negedge CLK);
        issue_cyc = cyc;
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 5'h08; bus_wdata = 32'h1234;
        @(negedge CLK);
        chk("strobe_h_before_rst", 64'(wr_mtimecmp_in_h), 64'd1);
        RST = 1'b1; bus_req = 1'b0;
        @(negedge CLK);
        chk("rst_mid_strobes", 64'({wr_en, wr_mtimecmp_in_l, wr_mtimecmp_in_h, bus_ack}), 64'd0);
        chk("rst_mid_cmp_h", 64'(mtimecmp_in_h), 64'hFFFF_FFFF);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        repeat (8) @(negedge CLK);

        for (int n = 0; n < 300; n++) begin
            logic [4:0] a;
            logic [2:0] pick;
            pick = 3'($urandom_range(0, 7));
            a = (pick < 6) ? 5'(pick * 4) : 5'($urandom);
            if ($urandom_range(0, 9) == 0) load_mtime({32'($urandom_range(0, 3)), 32'($urandom)});
            run = 1'($urandom);
            xact(1'($urandom), a, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
        end
        repeat (3) @(negedge CLK);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end
endmodule

// File: doc/timer_mmio_if.md
TIMER_MMIO_IF -- requirements
Module: timer_mmio_if

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, byte-address width of the register window.
REQ-002 SHALL have port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port RST  input  1  reset; synchronous and active-high.
REQ-004 SHALL have ports bus_req in 1, bus_we in 1, bus_addr in ADDR_W, bus_wdata in 32: CPU-side request, held stable by the requester until bus_ack.
REQ-005 SHALL have ports bus_ack out 1 (one-cycle completion pulse), bus_err out 1 (valid with bus_ack), bus_rdata out 32 (valid with bus_ack).
REQ-006 SHALL have ports en out 1, wr_en out 1, wr_mtimecmp_in_l out 1, wr_mtimecmp_in_h out 1, mtimecmp_in_l out 32, mtimecmp_in_h out 32: timer-side write interface.
REQ-007 SHALL have ports mtime_l in 32, mtime_h in 32, timer_int in 1: timer-side status.

Function
REQ-008 Register map (word-aligned byte offsets): 0x00 CTRL (bit0 = en, RW), 0x04 MTIMECMP_L (RW), 0x08 MTIMECMP_H (RW), 0x0C MTIME_L (RO), 0x10 MTIME_H (RO), 0x14 STATUS (bit0 = timer_int, RO).
REQ-009 FSM states SHALL be IDLE, STROBE, HOLD, ACK; a request is accepted only in IDLE with bus_req=1.
REQ-010 A write to CTRL/MTIMECMP_L/MTIMECMP_H SHALL latch bus_wdata into the matching output register (en, mtimecmp_in_l, mtimecmp_in_h) at acceptance, and only that output changes.
REQ-011 After a write is accepted, the matching strobe SHALL be high for exactly 2 cycles (STROBE), then low for 2 cycles (HOLD) with data unchanged, then bus_ack=1 for 1 cycle (ACK); acceptance edge to bus_ack = 5 cycles.
REQ-012 At most one strobe SHALL be high in any cycle; all strobes SHALL be low in IDLE and ACK.
REQ-013 A read of a mapped address SHALL go IDLE->ACK, with bus_ack and registered bus_rdata 1 cycle after acceptance; RW registers return their latched value.
REQ-014 A read of MTIME_L SHALL return mtime_l and, in the same cycle, capture mtime_h into a 32-bit shadow; a read of MTIME_H SHALL return the shadow (atomic 64-bit read, low first).
REQ-015 A write to an RO or unmapped address, a read of an unmapped address, or a non-word-aligned address SHALL go IDLE->ACK with bus_err=1, bus_rdata=0, no strobe and no register change.
REQ-016 bus_rdata and bus_err SHALL be 0 in every cycle where bus_ack=0.
REQ-017 bus_req during STROBE/HOLD/ACK SHALL be ignored; after ACK the FSM returns to IDLE and may accept a held request on the next cycle.
REQ-018 STATUS SHALL reflect timer_int sampled at acceptance.

Reset
REQ-019 RST=1 at any edge SHALL force IDLE, all strobes 0, bus_ack 0, bus_err 0, bus_rdata 0, en 0, mtimecmp_in_l and mtimecmp_in_h 0xFFFFFFFF, shadow 0; a write aborted mid-STROBE is never acknowledged.
REQ-020 Reset SHALL NOT generate any strobe; the timer's own state resets only via its own reset.

Structure
REQ-021 Register offsets, FSM state encoding and the strobe/hold cycle counts (2/2) SHALL live in a shared timer package used by the timer and this block.
REQ-022 No sub-module; one FSM plus a 1-bit phase counter.

Verification
REQ-023 Reset, then write 0x00=1 -> wr_en high cycles 1-2 after accept, en=1 from cycle 1, bus_ack at cycle 5, bus_err=0.
REQ-024 Write 0x04=0x10, then 0x08=0 -> each strobe 2 cycles high, no overlap; with counting timer, timer_int rises once mtime>=0x10; STATUS read returns 1.
REQ-025 mtime=0x1_FFFFFFFF: read 0x0C -> 0xFFFFFFFF; after mtime wraps to 0x2_00000000, read 0x10 -> 0x1 (shadow).
REQ-026 Write 0x0C=5 and read 0x18 -> bus_err=1, bus_rdata=0, ack 1 cycle after accept, no strobes.
REQ-027 Assert RST during STROBE of a 0x08 write -> strobes drop next edge, no bus_ack, mtimecmp_in_h=0xFFFFFFFF.
